// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: scan states,
// the dark segment pattern and the leading-zero blanking helper.
package seg_scan_ctrl_pkg;

  localparam int DIGITS_MAX = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GUARD = 2'd2
  } state_e;

  // Bit k set means digit k is a leading zero to be kept dark. Digit 0 is
  // never blanked. Digits at or above 'digits' are not present and stay 0.
  function automatic logic [DIGITS_MAX-1:0] lz_blank_mask(
    input logic [4*DIGITS_MAX-1:0] disp,
    input logic                    blank_lz,
    input int                      digits
  );
    logic [DIGITS_MAX-1:0] mask;
    logic                  zero_run;
    mask     = {DIGITS_MAX{1'b0}};
    zero_run = 1'b1;
    for (int k = DIGITS_MAX - 1; k >= 1; k--) begin
      if (k < digits) begin
        zero_run = zero_run & (disp[4*k +: 4] == 4'h0);
        mask[k]  = zero_run & blank_lz;
      end else begin
        mask[k]  = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to active-low seven-segment decoder
// (bit0 = segment a ... bit6 = segment g).
module seg_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  // Glyph lookup; the default arm keeps the pins dark on an unknown code.
  always_comb begin
    case (hex_i)
      4'h0:    seg_n_o = 7'b1000000;
      4'h1:    seg_n_o = 7'b1111001;
      4'h2:    seg_n_o = 7'b0100100;
      4'h3:    seg_n_o = 7'b0110000;
      4'h4:    seg_n_o = 7'b0011001;
      4'h5:    seg_n_o = 7'b0010010;
      4'h6:    seg_n_o = 7'b0000010;
      4'h7:    seg_n_o = 7'b1111000;
      4'h8:    seg_n_o = 7'b0000000;
      4'h9:    seg_n_o = 7'b0010000;
      4'hA:    seg_n_o = 7'b0001000;
      4'hB:    seg_n_o = 7'b0000011;
      4'hC:    seg_n_o = 7'b1000110;
      4'hD:    seg_n_o = 7'b0100001;
      4'hE:    seg_n_o = 7'b0000110;
      4'hF:    seg_n_o = 7'b0001110;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller. A staged
// value is only copied into the shown value at a frame boundary (or while
// idle), so a frame never mixes old and new digits. Pin outputs are
// registered from the next-state values so they line up with state/idx.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                blank_lz,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] load_data,
  output logic [6:0]          seg_n,
  output logic [DIGITS-1:0]   an_n,
  output logic                frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         dwell_cnt_q, dwell_cnt_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  load_accept;
  logic [4*DIGITS_MAX-1:0] disp_pad;
  logic [DIGITS_MAX-1:0] blank_mask;
  logic [2:0]            idx_ext;
  logic [3:0]            nib_sel;
  logic [6:0]            seg_dec;

  assign load_ready  = !pend_v_q;
  assign load_accept = load_valid && !pend_v_q;

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

  // Single shared decoder, fed the nibble of the digit about to be shown.
  seg_decode u_decode (
    .hex_i   (nib_sel),
    .seg_n_o (seg_dec)
  );

  // Next-state logic: scan sequencing, staging and boundary commit.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_cnt_d = dwell_cnt_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          disp_d   = pend_q;
          pend_v_d = 1'b0;
        end else begin
          disp_d   = disp_q;
        end
        if (enable) begin
          state_d     = SCAN;
          idx_d       = {IW{1'b0}};
          dwell_cnt_d = {CW{1'b0}};
        end else begin
          state_d     = IDLE;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d     = IDLE;
        end else if (dwell_cnt_q == DWELL_LAST) begin
          state_d     = GUARD;
          dwell_cnt_d = {CW{1'b0}};
        end else begin
          dwell_cnt_d = dwell_cnt_q + CW'(1);
        end
      end
      GUARD: begin
        if (!enable) begin
          state_d     = IDLE;
        end else begin
          state_d     = SCAN;
          dwell_cnt_d = {CW{1'b0}};
          if (idx_q == LAST_IDX) begin
            idx_d = {IW{1'b0}};
            if (pend_v_q) begin
              disp_d   = pend_q;
              pend_v_d = 1'b0;
            end else begin
              disp_d   = disp_q;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Staging never collides with a commit: a commit needs pend_v set,
    // acceptance needs it clear.
    if (load_accept) begin
      pend_d   = load_data;
      pend_v_d = 1'b1;
    end else begin
      pend_d   = pend_q;
    end
  end

  // Pin values for the next cycle, derived from the next state so they are
  // aligned with state/idx once registered.
  always_comb begin
    disp_pad                  = {(4*DIGITS_MAX){1'b0}};
    disp_pad[4*DIGITS-1:0]    = disp_d;
    blank_mask                = lz_blank_mask(disp_pad, blank_lz, DIGITS);
    idx_ext                   = 3'(idx_d);
    nib_sel                   = disp_pad[{idx_ext, 2'b00} +: 4];
    an_n_d                    = {DIGITS{1'b1}};
    seg_n_d                   = SEG_BLANK;
    if ((state_d == SCAN) && !blank_mask[idx_ext]) begin
      an_n_d[idx_d] = 1'b0;
      seg_n_d       = seg_dec;
    end else begin
      seg_n_d       = SEG_BLANK;
    end
    frame_done_d = (state_d == GUARD) && (idx_d == LAST_IDX);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= {IW{1'b0}};
      dwell_cnt_q  <= {CW{1'b0}};
      disp_q       <= {(4*DIGITS){1'b0}};
      pend_q       <= {(4*DIGITS){1'b0}};
      pend_v_q     <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= {DIGITS{1'b1}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS = 4, DWELL = 4
// (digit slot = 5 cycles, frame = 20 cycles).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        blank_lz;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks;
  int errors;

  seg_scan_ctrl #(.DIGITS(4), .DWELL(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks ncyc cycles starting at cycle 0 of a frame (digit 0 just lit).
  // s0..s3 are the hand-decoded glyphs per digit, lit marks unblanked
  // digits, rdy[c] is the expected load_ready in cycle c. Up to two loads
  // are offered at cycles ld_c / ld2_c (-1 = none).
  task automatic run_frame(input string tag,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] lit, input int ncyc,
                           input int ld_c, input logic [15:0] ld_v,
                           input int ld2_c, input logic [15:0] ld2_v,
                           input logic [19:0] rdy);
    logic [6:0] segs [4];
    logic [3:0] exp_an;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int c = 0; c < ncyc; c++) begin
      int slot;
      int pos;
      slot = c / 5;
      pos  = c % 5;
      if (pos == 4) begin
        check_eq({tag, " guard an_n"}, 32'(an_n), 32'hF);
        check_eq({tag, " guard seg_n"}, 32'(seg_n), 32'h7F);
      end else if (lit[slot]) begin
        exp_an = ~(4'b0001 << slot);
        check_eq({tag, " an_n"}, 32'(an_n), 32'(exp_an));
        check_eq({tag, " seg_n"}, 32'(seg_n), 32'(segs[slot]));
      end else begin
        check_eq({tag, " blanked an_n"}, 32'(an_n), 32'hF);
      end
      check_eq({tag, " frame_done"}, 32'(frame_done), 32'(c == 19));
      check_eq({tag, " load_ready"}, 32'(load_ready), 32'(rdy[c]));
      if (c == ld_c) begin
        load_valid = 1'b1;
        load_data  = ld_v;
      end else if (c == ld2_c) begin
        load_valid = 1'b1;
        load_data  = ld2_v;
      end else begin
        load_valid = 1'b0;
      end
      tick();
      load_valid = 1'b0;
      load_data  = 16'hDEAD;
    end
  endtask

  task automatic check_dark(input string tag, input logic exp_rdy);
    check_eq({tag, " an_n"}, 32'(an_n), 32'hF);
    check_eq({tag, " seg_n"}, 32'(seg_n), 32'h7F);
    check_eq({tag, " frame_done"}, 32'(frame_done), 32'h0);
    check_eq({tag, " load_ready"}, 32'(load_ready), 32'(exp_rdy));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    blank_lz   = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;

    // Reset state, then idle with enable low.
    repeat (3) @(negedge clk);
    check_dark("reset", 1'b1);
    rst_n = 1'b1;
    tick();
    tick();
    check_dark("idle", 1'b1);

    // Enable: digit 0 lit one edge later, zeros everywhere.
    enable = 1'b1;
    tick();
    run_frame("zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 20, -1, 16'h0, -1, 16'h0, 20'hFFFFF);

    // Mid-frame load: old value stays for the rest of this frame.
    run_frame("stage", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 20, 7, 16'h12AF, -1, 16'h0, 20'h000FF);

    // 12AF shown; stage 0030, then a second offer while full is refused.
    run_frame("hex12af", 7'h0E, 7'h08, 7'h24, 7'h79, 4'hF, 20, 2, 16'h0030, 10, 16'h5555, 20'h00007);

    // 0030 without blanking.
    run_frame("v0030", 7'h40, 7'h30, 7'h40, 7'h40, 4'hF, 20, -1, 16'h0, -1, 16'h0, 20'hFFFFF);

    // 0030 with leading-zero blanking; stage 0000.
    blank_lz = 1'b1;
    run_frame("lz0030", 7'h40, 7'h30, 7'h7F, 7'h7F, 4'b0011, 20, 1, 16'h0000, -1, 16'h0, 20'h00003);

    // 0000 blanked: only digit 0 lit.
    run_frame("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0001, 20, -1, 16'h0, -1, 16'h0, 20'hFFFFF);

    // Blanking off, stage 1234, drop enable inside digit 2's slot.
    blank_lz = 1'b0;
    run_frame("predrop", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 12, 2, 16'h1234, -1, 16'h0, 20'h00007);
    enable = 1'b0;
    tick();
    check_dark("drop", 1'b0);
    tick();
    check_dark("idle commit", 1'b1);
    tick();
    check_dark("idle hold", 1'b1);

    // Re-enable restarts at digit 0 showing the committed 1234.
    enable = 1'b1;
    tick();
    run_frame("hex1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 8, 3, 16'hBEEF, -1, 16'h0, 20'h0000F);

    // Asynchronous reset mid-SCAN with a value staged.
    #2;
    rst_n = 1'b0;
    #1;
    check_dark("async reset", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_frame("post reset", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 20, -1, 16'h0, -1, 16'h0, 20'hFFFFF);
    run_frame("no commit", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 20, -1, 16'h0, -1, 16'h0, 20'hFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
